frontend_cmd_issuer: RTL and testbench

//  Frontend-side initiator for the Backend_Controller command/read-return channel.

---
 rtl/frontend_cmd_issuer_pkg.sv | 33 +++
 rtl/frontend_cmd_issuer_if.sv | 28 ++
 rtl/frontend_cmd_issuer_fifo.sv | 64 ++++++
 rtl/frontend_cmd_issuer.sv | 154 +++++++++++++++
 tb/tb_frontend_cmd_issuer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frontend_cmd_issuer_pkg.sv
// Shared command-word definitions for the frontend/backend command channel,
// plus the issuer FSM state type.
package frontend_command_definition_pkg;

  localparam int DQ_BITS       = 8;
  localparam int ROW_ADDR_BITS = 14;
  localparam int COL_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_READ    = 2'd1,
    OP_WRITE   = 2'd2,
    OP_REFRESH = 2'd3
  } op_type_t;

  typedef struct packed {
    op_type_t                 op_type;
    logic [2:0]               bank_addr;
    logic [ROW_ADDR_BITS-1:0] row_addr;
    logic [COL_ADDR_BITS-1:0] col_addr;
    logic                     auto_precharge;
    logic [3:0]               tag;
  } frontend_command_t;

  localparam int FRONTEND_CMD_BITS = $bits(frontend_command_t);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BLOCK = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/frontend_cmd_issuer_if.sv
// Command / read-return channel between the frontend issuer (master) and the
// backend rank controller (slave).
interface frontend_backend_if
  import frontend_command_definition_pkg::*;
#(
  parameter int DATA_W = DQ_BITS * 8
);
  logic                         frontend_command_valid;
  logic                         backend_controller_ready;
  logic [FRONTEND_CMD_BITS-1:0] frontend_command;
  logic [DATA_W-1:0]            frontend_write_data;
  logic                         backend_read_data_valid;
  logic [DATA_W-1:0]            backend_read_data;
  logic                         backend_controller_stall;
  logic                         frontend_controller_ready;

  modport master (
    output frontend_command_valid, frontend_command, frontend_write_data,
           backend_controller_stall, frontend_controller_ready,
    input  backend_controller_ready, backend_read_data_valid, backend_read_data
  );

  modport slave (
    input  frontend_command_valid, frontend_command, frontend_write_data,
           backend_controller_stall, frontend_controller_ready,
    output backend_controller_ready, backend_read_data_valid, backend_read_data
  );
endinterface

// File: rtl/frontend_cmd_issuer_fifo.sv
// Synchronous FIFO with registered count/full/empty and a peek at the top
// PEEK_W bits of the entry behind the head. Push+pop at full is accepted.
module sync_fifo #(
  parameter int  WIDTH  = 8,
  parameter int  DEPTH  = 4,
  parameter int  PEEK_W = 1,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic [PEEK_W-1:0] peek,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CNT_W-1:0] count_d;
  logic             push_en, pop_en;

  assign pop_en    = pop & ~empty;
  assign push_en   = push & (~full | pop_en);
  assign rd_ptr_nx = rd_ptr + PTR_W'(1);

  always_comb begin
    count_d = count;
    if (push_en && !pop_en)      count_d = count + CNT_W'(1);
    else if (pop_en && !push_en) count_d = count - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr_nx;
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign peek  = mem[rd_ptr_nx][WIDTH-1 -: PEEK_W];

endmodule

// File: rtl/frontend_cmd_issuer.sv
// Frontend command issuer: queues host requests, issues them to the backend
// under read credit, and returns read beats to the host in order.
module frontend_cmd_issuer
  import frontend_command_definition_pkg::*;
#(
  parameter int DATA_W       = DQ_BITS * 8,
  parameter int ROW_BITS     = ROW_ADDR_BITS,
  parameter int COL_BITS     = COL_ADDR_BITS,
  parameter int CMD_DEPTH    = 4,
  parameter int RD_DEPTH     = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                clk,
  input  logic                power_on_rst_n,
  input  logic                i_host_req_valid,
  output logic                o_host_req_ready,
  input  logic                i_host_req_write,
  input  logic [ROW_BITS-1:0] i_host_req_row,
  input  logic [COL_BITS-1:0] i_host_req_col,
  input  logic [DATA_W-1:0]   i_host_req_wdata,
  frontend_backend_if.master  be,
  output logic                o_host_rdata_valid,
  input  logic                i_host_rdata_ready,
  output logic [DATA_W-1:0]   o_host_rdata,
  output logic                o_protocol_err
);

  localparam int CMD_W     = 1 + ROW_BITS + COL_BITS + DATA_W;
  localparam int CMD_CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int OCC_W     = $clog2(RD_DEPTH + 1);
  localparam int SUM_W     = OCC_W + 1;

  logic [CMD_W-1:0]     cmd_head;
  logic                 cmd_full, cmd_empty, cmd_pop, next_write;
  logic [CMD_CNT_W-1:0] cmd_count;
  logic [DATA_W-1:0]    rd_head;
  logic                 rd_full, rd_empty, rd_push, rd_peek_unused;
  logic [OCC_W-1:0]     rd_count;

  issuer_state_t     state_q, state_d;
  logic [OCC_W-1:0]  outstanding, outstanding_d;
  logic [SUM_W-1:0]  occ_next;
  logic              err_q, err_d, stall_q, stall_d;
  logic              head_write, issue_active, xfer, read_xfer;
  logic              beat, beat_counted, host_pop, credit_next;
  frontend_command_t cmd_word;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .PEEK_W(1)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (power_on_rst_n),
    .push  (i_host_req_valid & o_host_req_ready),
    .wdata ({i_host_req_write, i_host_req_row, i_host_req_col, i_host_req_wdata}),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .peek  (next_write),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RD_DEPTH), .PEEK_W(1)) u_rd_fifo (
    .clk   (clk),
    .rst_n (power_on_rst_n),
    .push  (rd_push),
    .wdata (be.backend_read_data),
    .pop   (host_pop),
    .rdata (rd_head),
    .peek  (rd_peek_unused),
    .full  (rd_full),
    .empty (rd_empty),
    .count (rd_count)
  );

  assign head_write   = cmd_head[CMD_W-1];
  assign issue_active = (state_q == S_ISSUE);
  assign xfer         = issue_active & be.backend_controller_ready;
  assign read_xfer    = xfer & ~head_write;
  assign beat         = be.backend_read_data_valid;
  assign beat_counted = beat & (outstanding != '0);
  assign rd_push      = beat_counted;
  assign host_pop     = o_host_rdata_valid & i_host_rdata_ready;

  // A returned beat moves from outstanding into the FIFO, so only read issue
  // and host pop change the total occupancy seen next cycle.
  assign occ_next    = SUM_W'(outstanding) + SUM_W'(rd_count)
                     + SUM_W'(read_xfer) - SUM_W'(host_pop);
  assign credit_next = (occ_next < SUM_W'(RD_DEPTH));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_d = state_q;
    cmd_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_empty) state_d = (head_write || credit_next) ? S_ISSUE : S_BLOCK;
      end
      S_BLOCK: begin
        if (credit_next) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (be.backend_controller_ready) begin
          cmd_pop = 1'b1;
          if (cmd_count > CMD_CNT_W'(1))
            state_d = (next_write || credit_next) ? S_ISSUE : S_BLOCK;
          else
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding;
    if (read_xfer && !beat_counted)      outstanding_d = outstanding + OCC_W'(1);
    else if (beat_counted && !read_xfer) outstanding_d = outstanding - OCC_W'(1);
  end

  assign err_d   = err_q | (beat & ((outstanding == '0) | (rd_full & ~host_pop)));
  assign stall_d = (RD_DEPTH - int'(rd_count)) <= STALL_MARGIN;

  always_ff @(posedge clk) begin
    if (!power_on_rst_n) begin
      state_q     <= S_IDLE;
      outstanding <= '0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
    end
  end

  always_comb begin
    cmd_word          = '0;
    cmd_word.op_type  = head_write ? OP_WRITE : OP_READ;
    cmd_word.row_addr = ROW_ADDR_BITS'(cmd_head[CMD_W-2 -: ROW_BITS]);
    cmd_word.col_addr = COL_ADDR_BITS'(cmd_head[DATA_W +: COL_BITS]);
  end

  assign o_host_req_ready             = ~cmd_full;
  assign be.frontend_command_valid    = issue_active & power_on_rst_n;
  assign be.frontend_command          = cmd_word;
  assign be.frontend_write_data       = cmd_head[DATA_W-1:0];
  assign be.backend_controller_stall  = stall_q & power_on_rst_n;
  assign be.frontend_controller_ready = ~rd_full;
  assign o_host_rdata_valid           = ~rd_empty & power_on_rst_n;
  assign o_host_rdata                 = rd_head;
  assign o_protocol_err               = err_q & power_on_rst_n;

endmodule

// File: tb/tb_frontend_cmd_issuer.sv
// Scoreboard bench for frontend_cmd_issuer: expected commands and read beats
// are queued at stimulus time and compared when the DUT presents them.
module tb_frontend_cmd_issuer;
  import frontend_command_definition_pkg::*;

  localparam int DATA_W   = 64;
  localparam int ROW_BITS = 14;
  localparam int COL_BITS = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                power_on_rst_n;
  logic                i_host_req_valid, o_host_req_ready, i_host_req_write;
  logic [ROW_BITS-1:0] i_host_req_row;
  logic [COL_BITS-1:0] i_host_req_col;
  logic [DATA_W-1:0]   i_host_req_wdata;
  logic                o_host_rdata_valid, i_host_rdata_ready;
  logic [DATA_W-1:0]   o_host_rdata;
  logic                o_protocol_err;

  frontend_backend_if #(.DATA_W(DATA_W)) be_if ();

  frontend_cmd_issuer #(
    .DATA_W(DATA_W), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
    .CMD_DEPTH(4), .RD_DEPTH(4), .STALL_MARGIN(1)
  ) dut (
    .clk                (clk),
    .power_on_rst_n     (power_on_rst_n),
    .i_host_req_valid   (i_host_req_valid),
    .o_host_req_ready   (o_host_req_ready),
    .i_host_req_write   (i_host_req_write),
    .i_host_req_row     (i_host_req_row),
    .i_host_req_col     (i_host_req_col),
    .i_host_req_wdata   (i_host_req_wdata),
    .be                 (be_if),
    .o_host_rdata_valid (o_host_rdata_valid),
    .i_host_rdata_ready (i_host_rdata_ready),
    .o_host_rdata       (o_host_rdata),
    .o_protocol_err     (o_protocol_err)
  );

  typedef struct {
    logic                write;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [DATA_W-1:0]   wdata;
  } cmd_exp_t;

  cmd_exp_t          cmd_q[$];
  logic [DATA_W-1:0] rd_q[$];
  int checks = 0, errors = 0;
  int n_xfer = 0, n_rd_xfer = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FRONTEND_CMD_BITS-1:0] model_cmd(input cmd_exp_t e);
    frontend_command_t c;
    c          = '0;
    c.op_type  = e.write ? OP_WRITE : OP_READ;
    c.row_addr = e.row;
    c.col_addr = e.col;
    return c;
  endfunction

  always @(negedge clk) begin : monitor
    cmd_exp_t e;
    if (power_on_rst_n) begin
      if (be_if.frontend_command_valid && be_if.backend_controller_ready) begin
        n_xfer++;
        if (cmd_q.size() == 0) check("xfer_unexpected", be_if.frontend_command_valid, 1'b0);
        else begin
          e = cmd_q.pop_front();
          check("xfer_cmd", be_if.frontend_command, model_cmd(e));
          if (e.write) check("xfer_wdata", be_if.frontend_write_data, e.wdata);
          else n_rd_xfer++;
        end
      end
      if (o_host_rdata_valid && i_host_rdata_ready) begin
        if (rd_q.size() == 0) check("pop_unexpected", o_host_rdata_valid, 1'b0);
        else check("pop_data", o_host_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic host_push(input logic wr, input logic [ROW_BITS-1:0] row,
                           input logic [COL_BITS-1:0] col, input logic [DATA_W-1:0] wd);
    int n = 0;
    i_host_req_valid = 1'b1;
    i_host_req_write = wr;
    i_host_req_row   = row;
    i_host_req_col   = col;
    i_host_req_wdata = wd;
    while (!o_host_req_ready && n < 50) begin tick(); n++; end
    if (n == 50) check("push_timeout", o_host_req_ready, 1'b1);
    @(posedge clk);
    cmd_q.push_back('{wr, row, col, wd});
    #1;
    i_host_req_valid = 1'b0;
  endtask

  task automatic backend_return(input logic [DATA_W-1:0] d, input logic keep);
    be_if.backend_read_data_valid = 1'b1;
    be_if.backend_read_data       = d;
    if (keep) rd_q.push_back(d);
    tick();
    be_if.backend_read_data_valid = 1'b0;
  endtask

  task automatic host_pop_one();
    int n = 0;
    while (!o_host_rdata_valid && n < 50) begin tick(); n++; end
    if (n == 50) check("pop_timeout", o_host_rdata_valid, 1'b1);
    i_host_rdata_ready = 1'b1;
    tick();
    i_host_rdata_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    cmd_exp_t e;
    power_on_rst_n = 1'b0;
    i_host_req_valid = 1'b0; i_host_req_write = 1'b0;
    i_host_req_row = '0; i_host_req_col = '0; i_host_req_wdata = '0;
    i_host_rdata_ready = 1'b0;
    be_if.backend_controller_ready = 1'b1;
    be_if.backend_read_data_valid  = 1'b0;
    be_if.backend_read_data        = '0;

    // Reset state
    wait_cycles(3);
    check("rst_cmd_valid", be_if.frontend_command_valid, 1'b0);
    check("rst_rdata_valid", o_host_rdata_valid, 1'b0);
    check("rst_stall", be_if.backend_controller_stall, 1'b0);
    check("rst_err", o_protocol_err, 1'b0);
    power_on_rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", o_host_req_ready, 1'b1);
    check("post_rst_fe_ready", be_if.frontend_controller_ready, 1'b1);

    // 1: single write, valid one cycle after accept
    host_push(1'b1, 14'h12, 10'h08, 64'hA5A5_A5A5_A5A5_A5A5);
    check("no_bypass", be_if.frontend_command_valid, 1'b0);
    tick();
    check("wr_valid", be_if.frontend_command_valid, 1'b1);
    check("wr_cmd", be_if.frontend_command,
          model_cmd('{1'b1, 14'h12, 10'h08, 64'hA5A5_A5A5_A5A5_A5A5}));
    check("wr_data", be_if.frontend_write_data, 64'hA5A5_A5A5_A5A5_A5A5);
    wait_cycles(3);

    // 2: read credit limit
    base = n_rd_xfer;
    for (int i = 0; i < 5; i++) host_push(1'b0, ROW_BITS'(i + 1), COL_BITS'(i * 3), '0);
    wait_cycles(8);
    check("rd_credit_limit", n_rd_xfer - base, 4);
    check("rd_blocked_valid", be_if.frontend_command_valid, 1'b0);
    backend_return(64'h1111_0000_0000_0001, 1'b1);
    wait_cycles(3);
    check("rd_still_blocked", n_rd_xfer - base, 4);
    host_pop_one();
    wait_cycles(3);
    check("rd_fifth_issued", n_rd_xfer - base, 5);
    for (int i = 0; i < 4; i++) backend_return(64'h2222_0000_0000_0000 | DATA_W'(i), 1'b1);
    check("rd_full_fe_ready", be_if.frontend_controller_ready, 1'b0);
    for (int i = 0; i < 4; i++) host_pop_one();
    wait_cycles(2);

    // 3: backpressure hold
    be_if.backend_controller_ready = 1'b0;
    host_push(1'b1, 14'h3FFF, 10'h3FF, 64'hDEAD_BEEF_0123_4567);
    begin
      int n = 0;
      while (!be_if.frontend_command_valid && n < 10) begin tick(); n++; end
    end
    e = '{1'b1, 14'h3FFF, 10'h3FF, 64'hDEAD_BEEF_0123_4567};
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", be_if.frontend_command_valid, 1'b1);
      check("hold_cmd", be_if.frontend_command, model_cmd(e));
      check("hold_wdata", be_if.frontend_write_data, e.wdata);
      tick();
    end
    base = n_xfer;
    be_if.backend_controller_ready = 1'b1;
    wait_cycles(3);
    check("hold_single_xfer", n_xfer - base, 1);

    // 4: stall threshold
    for (int i = 0; i < 3; i++) host_push(1'b0, 14'h100, COL_BITS'(i), '0);
    wait_cycles(6);
    for (int i = 0; i < 3; i++) backend_return(64'h4444_0000_0000_0000 | DATA_W'(i), 1'b1);
    check("stall_lag", be_if.backend_controller_stall, 1'b0);
    tick();
    check("stall_set", be_if.backend_controller_stall, 1'b1);
    host_pop_one();
    check("stall_hold", be_if.backend_controller_stall, 1'b1);
    tick();
    check("stall_clear", be_if.backend_controller_stall, 1'b0);
    host_pop_one();
    host_pop_one();
    wait_cycles(2);

    // 5: unexpected beat
    check("err_clear", o_protocol_err, 1'b0);
    backend_return(64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    check("err_set", o_protocol_err, 1'b1);
    check("drop_no_data", o_host_rdata_valid, 1'b0);
    wait_cycles(5);
    check("err_sticky", o_protocol_err, 1'b1);

    // 6: reset mid-traffic
    base = n_rd_xfer;
    host_push(1'b0, 14'h33, 10'h11, '0);
    wait_cycles(3);
    check("pre_rst_rd_issued", n_rd_xfer - base, 1);
    be_if.backend_controller_ready = 1'b0;
    host_push(1'b1, 14'h44, 10'h22, 64'h1);
    host_push(1'b1, 14'h55, 10'h33, 64'h2);
    wait_cycles(2);
    check("pre_rst_valid", be_if.frontend_command_valid, 1'b1);
    power_on_rst_n = 1'b0;
    cmd_q.delete();
    tick();
    check("rst6_cmd_valid", be_if.frontend_command_valid, 1'b0);
    check("rst6_rdata_valid", o_host_rdata_valid, 1'b0);
    check("rst6_err", o_protocol_err, 1'b0);
    check("rst6_stall", be_if.backend_controller_stall, 1'b0);
    power_on_rst_n = 1'b1;
    be_if.backend_controller_ready = 1'b1;
    tick();
    check("rst6_req_ready", o_host_req_ready, 1'b1);
    check("rst6_fe_ready", be_if.frontend_controller_ready, 1'b1);
    wait_cycles(3);
    check("rst6_cmd_fifo_empty", be_if.frontend_command_valid, 1'b0);
    check("rst6_rd_fifo_empty", o_host_rdata_valid, 1'b0);
    backend_return(64'h6666_6666_6666_6666, 1'b0);
    check("rst6_outstanding_zero", o_protocol_err, 1'b1);

    check("cmd_q_drained", cmd_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
